// File: rtl/multi_product_selector.sv
// -----------------------------------------------------------------------------
// multi_product_selector
//
// Product selector for the vending machine datapath. It holds a price table
// (writable at runtime) and, optionally, a stock counter per product. It
// latches a customer selection and runs a fixed-length dispense sequence that
// ends with a one-cycle done pulse.
//
// Optional feature macro: PS_STOCK_EN
//   defined   : per-product stock counters, restock port and sold_out pulse.
//   undefined : every product is always available, sold_out is held at 0 and
//               the restock_* inputs are ignored.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   sel_valid/idx   : selection request strobe and product index
//   price_wr_*      : price table write (enable, index, data)
//   restock_*       : add restock_qty to the stock of restock_idx
//   dispense_en     : credit is sufficient, start dispensing the held product
//   cancel          : abandon the held selection
//   product_out     : latched product index
//   product_price   : price latched together with the selection
//   product_valid   : a selection is currently held
//   invalid_sel     : one-cycle pulse, requested index out of range
//   sold_out        : one-cycle pulse, requested product has no stock
//   dispense_busy   : high while the product is being dispensed
//   dispense_done   : one-cycle pulse after the dispense window
// -----------------------------------------------------------------------------
module multi_product_selector #(
  parameter int NUM_PRODUCTS    = 4,
  parameter int PRICE_W         = 5,
  parameter int STOCK_W         = 4,
  parameter int DEFAULT_PRICE   = 10,
  parameter int DEFAULT_STOCK   = 5,
  parameter int DISPENSE_CYCLES = 3,
  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel_idx,
  input  logic               price_wr_en,
  input  logic [SEL_W-1:0]   price_wr_idx,
  input  logic [PRICE_W-1:0] price_wr_data,
  input  logic               restock_en,
  input  logic [SEL_W-1:0]   restock_idx,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               dispense_en,
  input  logic               cancel,
  output logic [SEL_W-1:0]   product_out,
  output logic [PRICE_W-1:0] product_price,
  output logic               product_valid,
  output logic               invalid_sel,
  output logic               sold_out,
  output logic               dispense_busy,
  output logic               dispense_done
);

  localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [SEL_W:0]   NUM_P      = (SEL_W+1)'(NUM_PRODUCTS);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(DISPENSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [PRICE_W-1:0] price_tbl [NUM_PRODUCTS];
  logic               stock_zero;

  // Decisions made in the combinational process, consumed by the registers.
  logic load_sel;
  logic inv_pulse;
  logic so_pulse;
  logic dec_fire;

  // Index comparison done one bit wider so NUM_PRODUCTS == 2**SEL_W works.
  function automatic logic in_range(input logic [SEL_W-1:0] idx);
    return ({1'b0, idx} < NUM_P);
  endfunction

  // ---------------------------------------------------------------------------
  // Stock storage
  // ---------------------------------------------------------------------------
`ifdef PS_STOCK_EN
  logic [STOCK_W-1:0] stock_tbl [NUM_PRODUCTS];
  logic [STOCK_W-1:0] stock_nx  [NUM_PRODUCTS];

  function automatic logic [STOCK_W-1:0] sat_stock(input logic [STOCK_W:0] v);
    return v[STOCK_W] ? {STOCK_W{1'b1}} : v[STOCK_W-1:0];
  endfunction

  // Restock and the dispense decrement are folded into one sum before
  // saturating, so a simultaneous restock + dispense yields sat(s + q - 1).
  function automatic logic [STOCK_W-1:0] next_stock(
    input logic [STOCK_W-1:0] cur,
    input logic               add_en,
    input logic [STOCK_W-1:0] qty,
    input logic               dec
  );
    logic [STOCK_W:0] sum;
    sum = {1'b0, cur};
    if (add_en)
      sum = sum + {1'b0, qty};
    if (dec && (sum != '0))
      sum = sum - 1'b1;
    return sat_stock(sum);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      stock_nx[i] = next_stock(stock_tbl[i],
                               restock_en && (restock_idx == SEL_W'(i)),
                               restock_qty,
                               dec_fire && (product_out == SEL_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock_tbl[i] <= STOCK_W'(DEFAULT_STOCK);
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock_tbl[i] <= stock_nx[i];
    end
  end

  assign stock_zero = in_range(sel_idx) && (stock_tbl[sel_idx] == '0);
`else
  logic unused_restock;
  assign unused_restock = ^{restock_en, restock_idx, restock_qty,
                            STOCK_W'(DEFAULT_STOCK)};
  assign stock_zero     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Price table: the selection reads the pre-write value on a shared edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRODUCTS; i++)
        price_tbl[i] <= PRICE_W'(DEFAULT_PRICE);
    end else if (price_wr_en && in_range(price_wr_idx)) begin
      price_tbl[price_wr_idx] <= price_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and per-edge decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    load_sel  = 1'b0;
    inv_pulse = 1'b0;
    so_pulse  = 1'b0;
    dec_fire  = 1'b0;

    case (state)
      IDLE, SELECTED: begin
        if ((state == SELECTED) && cancel) begin
          state_nx = IDLE;
        end else if ((state == SELECTED) && dispense_en) begin
          state_nx = DISPENSE;
          dec_fire = 1'b1;
        end else if (sel_valid) begin
          if (!in_range(sel_idx)) begin
            inv_pulse = 1'b1;
          end else if (stock_zero) begin
            so_pulse = 1'b1;
            state_nx = IDLE;
          end else begin
            load_sel = 1'b1;
            state_nx = SELECTED;
          end
        end
      end
      DISPENSE: begin
        if (cnt == '0)
          state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Selection latches, status pulses and dispense down-counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_out   <= '0;
      product_price <= '0;
      invalid_sel   <= 1'b0;
      sold_out      <= 1'b0;
      cnt           <= '0;
    end else begin
      invalid_sel <= inv_pulse;
      sold_out    <= so_pulse;
      if (load_sel) begin
        product_out   <= sel_idx;
        product_price <= price_tbl[sel_idx];
      end
      if (dec_fire)
        cnt <= CNT_LOAD;
      else if ((state == DISPENSE) && (cnt != '0))
        cnt <= cnt - 1'b1;
    end
  end

  assign product_valid = (state == SELECTED);
  assign dispense_busy = (state == DISPENSE);
  assign dispense_done = (state == DONE);

endmodule

// File: tb/tb_multi_product_selector.sv
// -----------------------------------------------------------------------------
// tb_multi_product_selector
//
// Directed scenarios followed by a randomized phase. Expected outputs come
// from a transaction-level model: a held flag, a remaining-busy-cycle count,
// a done flag and integer price/stock tables updated with plain arithmetic.
// Works with PS_STOCK_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_multi_product_selector;

  localparam int NP    = 4;
  localparam int PW    = 5;
  localparam int SW    = 4;
  localparam int DP    = 10;
  localparam int DS    = 5;
  localparam int DC    = 3;
  localparam int SEL_W = 2;
  localparam int SMAX  = (1 << SW) - 1;
`ifdef PS_STOCK_EN
  localparam bit STOCK_EN = 1'b1;
`else
  localparam bit STOCK_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             sel_valid;
  logic [SEL_W-1:0] sel_idx;
  logic             price_wr_en;
  logic [SEL_W-1:0] price_wr_idx;
  logic [PW-1:0]    price_wr_data;
  logic             restock_en;
  logic [SEL_W-1:0] restock_idx;
  logic [SW-1:0]    restock_qty;
  logic             dispense_en;
  logic             cancel;
  logic [SEL_W-1:0] product_out;
  logic [PW-1:0]    product_price;
  logic             product_valid;
  logic             invalid_sel;
  logic             sold_out;
  logic             dispense_busy;
  logic             dispense_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_price [NP];
  int m_stock [NP];
  bit m_held;
  int m_busy_left;
  bit m_done;
  int m_out;
  int m_pprice;
  bit m_inv;
  bit m_so;

  multi_product_selector #(
    .NUM_PRODUCTS    (NP),
    .PRICE_W         (PW),
    .STOCK_W         (SW),
    .DEFAULT_PRICE   (DP),
    .DEFAULT_STOCK   (DS),
    .DISPENSE_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_valid     (sel_valid),
    .sel_idx       (sel_idx),
    .price_wr_en   (price_wr_en),
    .price_wr_idx  (price_wr_idx),
    .price_wr_data (price_wr_data),
    .restock_en    (restock_en),
    .restock_idx   (restock_idx),
    .restock_qty   (restock_qty),
    .dispense_en   (dispense_en),
    .cancel        (cancel),
    .product_out   (product_out),
    .product_price (product_price),
    .product_valid (product_valid),
    .invalid_sel   (invalid_sel),
    .sold_out      (sold_out),
    .dispense_busy (dispense_busy),
    .dispense_done (dispense_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_price[i] = DP;
      m_stock[i] = DS;
    end
    m_held = 0; m_busy_left = 0; m_done = 0;
    m_out = 0; m_pprice = 0; m_inv = 0; m_so = 0;
  endtask

  // One clock edge of the vending rules, using the inputs present at the edge.
  task automatic model_edge();
    int dec_idx;
    dec_idx = -1;
    m_inv = 0;
    m_so  = 0;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_held && cancel) begin
      m_held = 0;
    end else if (m_held && dispense_en) begin
      m_held      = 0;
      m_busy_left = DC;
      dec_idx     = m_out;
    end else if (sel_valid) begin
      if (int'(sel_idx) >= NP) begin
        m_inv = 1;
      end else if (STOCK_EN && m_stock[sel_idx] == 0) begin
        m_so   = 1;
        m_held = 0;
      end else begin
        m_out    = int'(sel_idx);
        m_pprice = m_price[sel_idx];
        m_held   = 1;
      end
    end
    if (price_wr_en && int'(price_wr_idx) < NP)
      m_price[price_wr_idx] = int'(price_wr_data);
    for (int i = 0; i < NP; i++) begin
      int s;
      s = m_stock[i];
      if (restock_en && int'(restock_idx) == i) s += int'(restock_qty);
      if (dec_idx == i && s > 0) s--;
      if (s > SMAX) s = SMAX;
      m_stock[i] = s;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".product_out"},   32'(product_out),   32'(m_out));
    chk({ctx, ".product_price"}, 32'(product_price), 32'(m_pprice));
    chk({ctx, ".product_valid"}, 32'(product_valid), 32'(m_held));
    chk({ctx, ".invalid_sel"},   32'(invalid_sel),   32'(m_inv));
    chk({ctx, ".sold_out"},      32'(sold_out),      32'(m_so));
    chk({ctx, ".dispense_busy"}, 32'(dispense_busy), 32'(m_busy_left > 0));
    chk({ctx, ".dispense_done"}, 32'(dispense_done), 32'(m_done));
  endtask

  task automatic clear_inputs();
    sel_valid = 0; sel_idx = '0;
    price_wr_en = 0; price_wr_idx = '0; price_wr_data = '0;
    restock_en = 0; restock_idx = '0; restock_qty = '0;
    dispense_en = 0; cancel = 0;
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  // Select, dispense, run the busy window up to the done cycle, then idle.
  task automatic vend(input int idx);
    clear_inputs(); sel_valid = 1; sel_idx = SEL_W'(idx);
    step("vend_sel");
    clear_inputs(); dispense_en = 1;
    step("vend_disp");
    clear_inputs();
    repeat (DC) step("vend_busy");
    step("vend_idle");
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1;

    // Reset state
    @(negedge clk);
    check_all("reset");
    rst = 0;

    // Basic vend of product 1
    @(posedge clk); #1;
    sel_valid = 1; sel_idx = 2'd1;
    step("basic_sel");
    chk("basic_out", 32'(product_out), 32'd1);
    chk("basic_price", 32'(product_price), 32'd10);
    chk("basic_valid", 32'(product_valid), 32'd1);
    clear_inputs(); dispense_en = 1;
    step("basic_disp");
    clear_inputs();
    repeat (DC - 1) step("basic_busy");
    chk("basic_busy_last", 32'(dispense_busy), 32'd1);
    step("basic_done");
    chk("basic_done_pulse", 32'(dispense_done), 32'd1);
    step("basic_idle");
    chk("basic_idle_done", 32'(dispense_done), 32'd0);

    // Price write then select, later write must not disturb latched price
    price_wr_en = 1; price_wr_idx = 2'd2; price_wr_data = 5'd17;
    step("pw_write");
    clear_inputs(); sel_valid = 1; sel_idx = 2'd2;
    step("pw_sel");
    chk("pw_price17", 32'(product_price), 32'd17);
    clear_inputs(); price_wr_en = 1; price_wr_idx = 2'd2; price_wr_data = 5'd3;
    step("pw_rewrite");
    chk("pw_keep17", 32'(product_price), 32'd17);
    clear_inputs(); cancel = 1;
    step("pw_cancel");

    // Same-cycle selection and price write latches the old price
    clear_inputs(); sel_valid = 1; sel_idx = 2'd0;
    price_wr_en = 1; price_wr_idx = 2'd0; price_wr_data = 5'd20;
    step("pw_same");
    chk("pw_same_old", 32'(product_price), 32'd10);
    clear_inputs(); cancel = 1;
    step("pw_same_cancel");

    // cancel together with dispense_en: cancel wins
    clear_inputs(); sel_valid = 1; sel_idx = 2'd1;
    step("cd_sel");
    clear_inputs(); cancel = 1; dispense_en = 1;
    step("cd_both");
    chk("cd_valid", 32'(product_valid), 32'd0);
    chk("cd_busy", 32'(dispense_busy), 32'd0);

    // sel_valid during DISPENSE is ignored
    clear_inputs(); sel_valid = 1; sel_idx = 2'd1;
    step("sd_sel");
    clear_inputs(); dispense_en = 1;
    step("sd_disp");
    clear_inputs(); sel_valid = 1; sel_idx = 2'd3; cancel = 1;
    repeat (DC) step("sd_busy");
    chk("sd_out_kept", 32'(product_out), 32'd1);
    clear_inputs();
    step("sd_idle");

`ifdef PS_STOCK_EN
    // Sold out: product 0 starts with DS units
    for (int k = 0; k < DS; k++) vend(0);
    clear_inputs(); sel_valid = 1; sel_idx = 2'd0;
    step("so_sel");
    chk("so_pulse", 32'(sold_out), 32'd1);
    chk("so_valid", 32'(product_valid), 32'd0);
    clear_inputs(); restock_en = 1; restock_idx = 2'd0; restock_qty = 4'd2;
    step("so_restock");
    clear_inputs(); sel_valid = 1; sel_idx = 2'd0;
    step("so_resel");
    chk("so_resel_valid", 32'(product_valid), 32'd1);
    clear_inputs(); cancel = 1;
    step("so_cancel");

    // Restock and dispense on the same edge: stock 4 + 2 - 1 = 5
    vend(2);
    clear_inputs(); sel_valid = 1; sel_idx = 2'd2;
    step("rd_sel");
    clear_inputs(); dispense_en = 1;
    restock_en = 1; restock_idx = 2'd2; restock_qty = 4'd2;
    step("rd_both");
    clear_inputs();
    repeat (DC + 1) step("rd_run");
    for (int k = 0; k < 5; k++) vend(2);
    clear_inputs(); sel_valid = 1; sel_idx = 2'd2;
    step("rd_empty");
    chk("rd_sold_out", 32'(sold_out), 32'd1);

    // Saturation: restock 15 twice, only 15 units are vendable
    clear_inputs(); restock_en = 1; restock_idx = 2'd3; restock_qty = 4'd15;
    step("sat_r1");
    step("sat_r2");
    for (int k = 0; k < SMAX; k++) vend(3);
    clear_inputs(); sel_valid = 1; sel_idx = 2'd3;
    step("sat_empty");
    chk("sat_sold_out", 32'(sold_out), 32'd1);
`else
    // No stock tracking: product 3 never runs out
    for (int k = 0; k < 10; k++) begin
      clear_inputs(); sel_valid = 1; sel_idx = 2'd3;
      step("ns_sel");
      chk("ns_sold_out", 32'(sold_out), 32'd0);
      chk("ns_valid", 32'(product_valid), 32'd1);
      clear_inputs(); dispense_en = 1;
      step("ns_disp");
      clear_inputs();
      repeat (DC) step("ns_busy");
      chk("ns_done", 32'(dispense_done), 32'd1);
      step("ns_idle");
    end
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      clear_inputs();
      sel_valid     = ($urandom_range(0, 99) < 35);
      sel_idx       = SEL_W'($urandom_range(0, NP - 1));
      price_wr_en   = ($urandom_range(0, 99) < 10);
      price_wr_idx  = SEL_W'($urandom_range(0, NP - 1));
      price_wr_data = PW'($urandom);
      restock_en    = ($urandom_range(0, 99) < 8);
      restock_idx   = SEL_W'($urandom_range(0, NP - 1));
      restock_qty   = SW'($urandom);
      dispense_en   = ($urandom_range(0, 99) < 30);
      cancel        = ($urandom_range(0, 99) < 8);
      step("rand");
    end

    // Asynchronous reset in the middle of a dispense
    clear_inputs(); sel_valid = 1; sel_idx = 2'd1;
    step("rst_sel");
    clear_inputs(); dispense_en = 1;
    step("rst_disp");
    clear_inputs();
    step("rst_busy");
    #2 rst = 1;
    #1;
    model_reset();
    check_all("rst_async");
    chk("rst_busy_low", 32'(dispense_busy), 32'd0);
    #2 rst = 0;
    clear_inputs(); sel_valid = 1; sel_idx = 2'd2;
    step("rst_after_sel");
    chk("rst_default_price", 32'(product_price), 32'(DP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_product_selector.md
# multi_product_selector

Parametrised product selector for the vending machine datapath. It supports `NUM_PRODUCTS` products, each with a runtime-writable price table and a per-product stock counter. It also runs a timed dispense sequence with a done pulse. It sits between the coin/credit logic, which issues `dispense_en`, and the motor/dispense driver, which consumes `product_out` and `dispense_busy`.

## Interface
Parameters:
- `NUM_PRODUCTS`, 4: number of products; index width `SEL_W = max(1, $clog2(NUM_PRODUCTS))` (localparam).
- `PRICE_W`, 5: price width in credit units.
- `STOCK_W`, 4: stock counter width.
- `DEFAULT_PRICE`, 10: price of every product after reset.
- `DEFAULT_STOCK`, 5: stock of every product after reset (PS_STOCK_EN only).
- `DISPENSE_CYCLES`, 3: cycles `dispense_busy` stays high; must be ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `sel_valid`, in, 1: selection request strobe.
- `sel_idx`, in, SEL_W: requested product index.
- `price_wr_en`, in, 1: price table write.
- `price_wr_idx`, in, SEL_W: price write index.
- `price_wr_data`, in, PRICE_W: new price.
- `restock_en`, in, 1: add stock (PS_STOCK_EN only; ignored otherwise).
- `restock_idx`, in, SEL_W: restock index.
- `restock_qty`, in, STOCK_W: quantity to add.
- `dispense_en`, in, 1: credit sufficient; start dispense.
- `cancel`, in, 1: abandon the current selection.
- `product_out`, out, SEL_W: latched selected index.
- `product_price`, out, PRICE_W: price latched at selection.
- `product_valid`, out, 1: a selection is held (state SELECTED).
- `invalid_sel`, out, 1: one-cycle pulse; index ≥ `NUM_PRODUCTS`.
- `sold_out`, out, 1: one-cycle pulse; selected product has stock 0.
- `dispense_busy`, out, 1: high in DISPENSE.
- `dispense_done`, out, 1: one-cycle pulse at the end of a dispense.

## Operation
- FSM states: IDLE, SELECTED, DISPENSE, DONE. Reset state is IDLE.
- **IDLE / SELECTED with `sel_valid`:**
  - Index out of range → `invalid_sel` pulse; state and latches unchanged.
  - Stock 0 → `sold_out` pulse; go to IDLE and clear `product_valid`.
  - Otherwise latch `product_out`/`product_price` from the table and go to SELECTED. Reselecting in SELECTED is allowed.
- **SELECTED:**
  - `cancel` → IDLE.
  - `dispense_en` → DISPENSE; decrement the stock of `product_out` on the same edge.
  - Priority: `cancel` > `dispense_en` > `sel_valid`.
- **DISPENSE:**
  - Down-counter loads `DISPENSE_CYCLES-1` on entry.
  - State goes to DONE when the counter reaches 0.
  - `sel_valid`, `cancel` and `dispense_en` are ignored.
- **DONE:** one cycle; `dispense_done`=1; then IDLE. `product_out`/`product_price` keep their values until the next accepted selection.
- **Price writes:** accepted in any state, effective the next cycle. They do not alter an already latched `product_price`.
- **Restock:** stock saturates at `2^STOCK_W-1`.
- **Restock and dispense-decrement on the same index, same edge:** result = sat(stock + qty − 1).
- **Selection and price write on the same index, same cycle:** the old price is latched.
- `dispense_en` outside SELECTED is ignored.

## Timing
- **Reset values:** `product_out`=0, `product_price`=0, `product_valid`=0, `invalid_sel`=0, `sold_out`=0, `dispense_busy`=0, `dispense_done`=0. Price table is all `DEFAULT_PRICE`, stock is all `DEFAULT_STOCK`, state is IDLE.
- **Selection latency:** `sel_valid` sampled at edge k → outputs and pulses valid after edge k (registered, 1 cycle).
- **Dispense:** `dispense_en` at edge k → `dispense_busy` high for `DISPENSE_CYCLES` cycles starting after k → `dispense_done` high for the following cycle → IDLE.
- **Reset mid-dispense:** immediate return to IDLE. All outputs go to their reset values, and tables return to their defaults.

## Configuration
- `PS_STOCK_EN` defined:
  - Stock counters, restock port and `sold_out` logic are compiled in.
- `PS_STOCK_EN` undefined:
  - No stock storage; every product is always available.
  - `sold_out` is tied to 0, and the `restock_*` inputs are ignored.
  - Selection, price table and dispense timing are unchanged.

## Test plan
All scenarios use defaults, with `PS_STOCK_EN` defined unless stated.
- **Basic vend:** release reset; sel_idx=1, sel_valid → next cycle `product_out`=1, `product_price`=10, `product_valid`=1. Then dispense_en → `dispense_busy` for 3 cycles, `dispense_done` for 1 cycle, state IDLE, stock[1]=4.
- **Price write:** write price[2]=17, then select 2 → `product_price`=17. Writing price[2]=3 while SELECTED → `product_price` stays 17.
- **Sold out:** vend product 0 five times; a sixth selection → `sold_out` pulse, `product_valid`=0. Restock qty=2 → selection succeeds.
- **Boundaries:**
  - Restock qty=15 on a full counter → stock stays 15.
  - Restock and dispense on the same index, same edge, with stock 4 and qty 2 → stock 5.
- **Control and reset:**
  - `cancel` with `dispense_en` in SELECTED → IDLE, stock unchanged.
  - `sel_valid` during DISPENSE → ignored.
  - `rst` asserted mid-DISPENSE → all outputs 0 asynchronously.
- **Without `PS_STOCK_EN`:** ten consecutive vends of product 3 → never `sold_out`, each completes with `dispense_done`.
